// File: rtl/gobang_board_store.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gobang_board_store: colour bitmaps, move history/undo, rows and windows. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gobang_board_store #(
  parameter  int BOARD_SIZE = 15,
  parameter  int RADIUS     = 4,
  parameter  int HIST_DEPTH = 225,
  localparam int IW         = $clog2(BOARD_SIZE),
  localparam int CW         = $clog2(HIST_DEPTH + 1),
  localparam int WL         = 2 * RADIUS + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  place_req,
  input  logic [IW-1:0]         place_i,
  input  logic [IW-1:0]         place_j,
  input  logic                  place_color,
  output logic                  place_ack,
  output logic                  place_err,
  input  logic                  undo_req,
  output logic                  undo_ack,
  output logic                  undo_err,
  output logic [CW-1:0]         move_count,
  output logic                  last_valid,
  output logic [IW-1:0]         last_i,
  output logic [IW-1:0]         last_j,
  output logic                  last_color,
  output logic                  board_full,
  input  logic [IW-1:0]         row_sel,
  output logic [BOARD_SIZE-1:0] row_black,
  output logic [BOARD_SIZE-1:0] row_white,
  input  logic                  win_req,
  input  logic [IW-1:0]         win_i,
  input  logic [IW-1:0]         win_j,
  output logic                  win_valid,
  output logic [4*WL-1:0]       win_black,
  output logic [4*WL-1:0]       win_white
);

  logic [BOARD_SIZE-1:0][BOARD_SIZE-1:0] black_q, black_d, white_q, white_d;
  logic [CW-1:0]   count_q, count_d, top;
  logic [IW-1:0]   hist_i_q [HIST_DEPTH];
  logic [IW-1:0]   hist_j_q [HIST_DEPTH];
  logic            hist_c_q [HIST_DEPTH];
  logic            hist_we;
  logic            place_ack_q, place_ack_d, place_err_q, place_err_d;
  logic            undo_ack_q, undo_ack_d, undo_err_q, undo_err_d;
  logic            win_valid_q, win_valid_d;
  logic [4*WL-1:0] win_black_q, win_black_d, win_white_q, win_white_d;
  logic            place_legal;

  function automatic logic cell_at(input logic [BOARD_SIZE-1:0][BOARD_SIZE-1:0] b,
                                   input int r, input int c);
    logic v;
    v = 1'b0;
    if (r >= 0 && r < BOARD_SIZE && c >= 0 && c < BOARD_SIZE)
      v = b[r[IW-1:0]][c[IW-1:0]];
    return v;
  endfunction

  assign top        = count_q - CW'(1);
  assign last_valid = (count_q != '0);
  assign last_i     = last_valid ? hist_i_q[top] : '0;
  assign last_j     = last_valid ? hist_j_q[top] : '0;
  assign last_color = last_valid ? hist_c_q[top] : 1'b0;
  assign board_full = (int'(count_q) == HIST_DEPTH);
  assign move_count = count_q;
  assign row_black  = (int'(row_sel) < BOARD_SIZE) ? black_q[row_sel] : '0;
  assign row_white  = (int'(row_sel) < BOARD_SIZE) ? white_q[row_sel] : '0;

  assign place_legal = (int'(place_i) < BOARD_SIZE) && (int'(place_j) < BOARD_SIZE) &&
                       !board_full && !black_q[place_i][place_j] && !white_q[place_i][place_j];

  // Priority clr > undo > place; a place alongside any undo is always rejected.
  always_comb begin
    black_d     = black_q;
    white_d     = white_q;
    count_d     = count_q;
    hist_we     = 1'b0;
    place_ack_d = 1'b0;
    place_err_d = 1'b0;
    undo_ack_d  = 1'b0;
    undo_err_d  = 1'b0;
    if (clr) begin
      black_d = '0;
      white_d = '0;
      count_d = '0;
    end else if (undo_req) begin
      place_err_d = place_req;
      if (last_valid) begin
        black_d[hist_i_q[top]][hist_j_q[top]] = 1'b0;
        white_d[hist_i_q[top]][hist_j_q[top]] = 1'b0;
        count_d    = top;
        undo_ack_d = 1'b1;
      end else begin
        undo_err_d = 1'b1;
      end
    end else if (place_req) begin
      if (place_legal) begin
        if (place_color) white_d[place_i][place_j] = 1'b1;
        else             black_d[place_i][place_j] = 1'b1;
        count_d     = count_q + CW'(1);
        hist_we     = 1'b1;
        place_ack_d = 1'b1;
      end else begin
        place_err_d = 1'b1;
      end
    end
  end

  // Windows read the pre-write board so they see state before this edge's move.
  always_comb begin
    win_black_d = win_black_q;
    win_white_d = win_white_q;
    win_valid_d = win_req;
    if (win_req) begin
      for (int k = 0; k < WL; k++) begin
        win_black_d[k]        = cell_at(black_q, int'(win_i), int'(win_j) + k - RADIUS);
        win_black_d[WL+k]     = cell_at(black_q, int'(win_i) + k - RADIUS, int'(win_j));
        win_black_d[2*WL+k]   = cell_at(black_q, int'(win_i) + k - RADIUS, int'(win_j) + k - RADIUS);
        win_black_d[3*WL+k]   = cell_at(black_q, int'(win_i) - k + RADIUS, int'(win_j) + k - RADIUS);
        win_white_d[k]        = cell_at(white_q, int'(win_i), int'(win_j) + k - RADIUS);
        win_white_d[WL+k]     = cell_at(white_q, int'(win_i) + k - RADIUS, int'(win_j));
        win_white_d[2*WL+k]   = cell_at(white_q, int'(win_i) + k - RADIUS, int'(win_j) + k - RADIUS);
        win_white_d[3*WL+k]   = cell_at(white_q, int'(win_i) - k + RADIUS, int'(win_j) + k - RADIUS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      black_q     <= '0;
      white_q     <= '0;
      count_q     <= '0;
      place_ack_q <= 1'b0;
      place_err_q <= 1'b0;
      undo_ack_q  <= 1'b0;
      undo_err_q  <= 1'b0;
      win_valid_q <= 1'b0;
      win_black_q <= '0;
      win_white_q <= '0;
    end else begin
      black_q     <= black_d;
      white_q     <= white_d;
      count_q     <= count_d;
      place_ack_q <= place_ack_d;
      place_err_q <= place_err_d;
      undo_ack_q  <= undo_ack_d;
      undo_err_q  <= undo_err_d;
      win_valid_q <= win_valid_d;
      win_black_q <= win_black_d;
      win_white_q <= win_white_d;
    end
  end

  // History entries above move_count are never observed, so they need no reset.
  always_ff @(posedge clk) begin
    if (hist_we) begin
      hist_i_q[count_q] <= place_i;
      hist_j_q[count_q] <= place_j;
      hist_c_q[count_q] <= place_color;
    end
  end

  assign place_ack = place_ack_q;
  assign place_err = place_err_q;
  assign undo_ack  = undo_ack_q;
  assign undo_err  = undo_err_q;
  assign win_valid = win_valid_q;
  assign win_black = win_black_q;
  assign win_white = win_white_q;

endmodule
`default_nettype wire

// File: tb/tb_gobang_board_store.sv
`default_nettype none
// Testbench for gobang_board_store: directed table, hand sequences, random vs. model.
module tb_gobang_board_store;
  localparam int BS = 15, R = 4, HD = 225, IW = 4, CW = 8, WL = 9;
  localparam int BS2 = 5, R2 = 2, HD2 = 4, IW2 = 3, CW2 = 3, WL2 = 5;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic clr = 0, place_req = 0, place_color = 0, undo_req = 0, win_req = 0;
  logic [IW-1:0] place_i = 0, place_j = 0, row_sel = 0, win_i = 0, win_j = 0;
  logic place_ack, place_err, undo_ack, undo_err, last_valid, last_color, board_full, win_valid;
  logic [CW-1:0] move_count;
  logic [IW-1:0] last_i, last_j;
  logic [BS-1:0] row_black, row_white;
  logic [4*WL-1:0] win_black, win_white;

  logic clr2 = 0, place_req2 = 0, place_color2 = 0, undo_req2 = 0, win_req2 = 0;
  logic [IW2-1:0] place_i2 = 0, place_j2 = 0, row_sel2 = 0, win_i2 = 0, win_j2 = 0;
  logic place_ack2, place_err2, undo_ack2, undo_err2, last_valid2, last_color2, board_full2, win_valid2;
  logic [CW2-1:0] move_count2;
  logic [IW2-1:0] last_i2, last_j2;
  logic [BS2-1:0] row_black2, row_white2;
  logic [4*WL2-1:0] win_black2, win_white2;

  gobang_board_store #(.BOARD_SIZE(BS), .RADIUS(R), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst(rst), .clr(clr), .place_req(place_req), .place_i(place_i), .place_j(place_j),
    .place_color(place_color), .place_ack(place_ack), .place_err(place_err), .undo_req(undo_req),
    .undo_ack(undo_ack), .undo_err(undo_err), .move_count(move_count), .last_valid(last_valid),
    .last_i(last_i), .last_j(last_j), .last_color(last_color), .board_full(board_full),
    .row_sel(row_sel), .row_black(row_black), .row_white(row_white), .win_req(win_req),
    .win_i(win_i), .win_j(win_j), .win_valid(win_valid), .win_black(win_black), .win_white(win_white));

  gobang_board_store #(.BOARD_SIZE(BS2), .RADIUS(R2), .HIST_DEPTH(HD2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr2), .place_req(place_req2), .place_i(place_i2), .place_j(place_j2),
    .place_color(place_color2), .place_ack(place_ack2), .place_err(place_err2), .undo_req(undo_req2),
    .undo_ack(undo_ack2), .undo_err(undo_err2), .move_count(move_count2), .last_valid(last_valid2),
    .last_i(last_i2), .last_j(last_j2), .last_color(last_color2), .board_full(board_full2),
    .row_sel(row_sel2), .row_black(row_black2), .row_white(row_white2), .win_req(win_req2),
    .win_i(win_i2), .win_j(win_j2), .win_valid(win_valid2), .win_black(win_black2), .win_white(win_white2));

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit u, input bit p, input int i, input int j, input bit col);
    clr = c; undo_req = u; place_req = p;
    place_i = IW'(i); place_j = IW'(j); place_color = col;
  endtask

  // Reference model: plain cell arrays plus a move stack.
  typedef struct { int i; int j; bit c; } mv_t;
  bit  mb [BS][BS];
  bit  mw [BS][BS];
  mv_t hq [$];

  function automatic bit mcell(input bit white, input int r, input int c);
    if (r < 0 || r >= BS || c < 0 || c >= BS) return 1'b0;
    return white ? mw[r][c] : mb[r][c];
  endfunction

  function automatic logic [4*WL-1:0] m_win(input bit white, input int ci, input int cj);
    logic [4*WL-1:0] w;
    w = '0;
    for (int k = 0; k < WL; k++) begin
      w[k]        = mcell(white, ci, cj + k - R);
      w[WL+k]     = mcell(white, ci + k - R, cj);
      w[2*WL+k]   = mcell(white, ci + k - R, cj + k - R);
      w[3*WL+k]   = mcell(white, ci - (k - R), cj + k - R);
    end
    return w;
  endfunction

  task automatic m_apply(input bit c, input bit u, input bit p, input int i, input int j, input bit col,
                         output bit ack, output bit err, output bit uack, output bit uerr);
    mv_t mv;
    ack = 0; err = 0; uack = 0; uerr = 0;
    if (c) begin
      for (int r = 0; r < BS; r++) for (int q = 0; q < BS; q++) begin mb[r][q] = 0; mw[r][q] = 0; end
      hq.delete();
    end else if (u) begin
      if (hq.size() > 0) begin
        mv = hq.pop_back();
        mb[mv.i][mv.j] = 0; mw[mv.i][mv.j] = 0;
        uack = 1;
      end else uerr = 1;
      err = p;
    end else if (p) begin
      if (i < BS && j < BS && hq.size() < HD && !mb[i][j] && !mw[i][j]) begin
        if (col) mw[i][j] = 1; else mb[i][j] = 1;
        mv.i = i; mv.j = j; mv.c = col;
        hq.push_back(mv);
        ack = 1;
      end else err = 1;
    end
  endtask

  typedef struct { bit clr; bit undo; bit place; int i; int j; bit col;
                   bit ack; bit err; bit uack; bit uerr; int cnt; } vec_t;
  vec_t vt [$];

  initial begin
    logic [4*WL-1:0] exp_wb, exp_ww;
    logic [BS-1:0] er_b, er_w;
    bit ea, ee, eua, eue;

    // Directed vectors: clr, undo, place, i, j, colour, ack, err, uack, uerr, count
    vt.push_back('{0,0,1, 7, 7,0, 1,0,0,0, 1});
    vt.push_back('{0,0,1, 7, 7,1, 0,1,0,0, 1});
    vt.push_back('{0,0,1,15, 3,0, 0,1,0,0, 1});
    vt.push_back('{0,0,1, 3, 3,0, 1,0,0,0, 2});
    vt.push_back('{0,0,1, 5, 5,0, 1,0,0,0, 3});
    vt.push_back('{0,1,0, 0, 0,0, 0,0,1,0, 2});
    vt.push_back('{0,1,0, 0, 0,0, 0,0,1,0, 1});
    vt.push_back('{0,1,0, 0, 0,0, 0,0,1,0, 0});
    vt.push_back('{0,1,0, 0, 0,0, 0,0,0,1, 0});
    vt.push_back('{0,0,1, 1, 1,0, 1,0,0,0, 1});
    vt.push_back('{0,0,1, 2, 2,1, 1,0,0,0, 2});
    vt.push_back('{0,1,1, 4, 4,0, 0,1,1,0, 1});
    vt.push_back('{0,0,1, 2, 2,0, 1,0,0,0, 2});
    vt.push_back('{1,1,1, 9, 9,0, 0,0,0,0, 0});
    vt.push_back('{0,0,1,14,14,1, 1,0,0,0, 1});
    vt.push_back('{0,0,1, 3,15,0, 0,1,0,0, 1});
    vt.push_back('{0,0,1,14,14,0, 0,1,0,0, 1});

    // Reset state
    tick(); tick();
    chk("rst_count", move_count, 0);
    chk("rst_last_valid", last_valid, 0);
    chk("rst_last_ij", {last_i, last_j, last_color}, 0);
    chk("rst_pulses", {place_ack, place_err, undo_ack, undo_err, win_valid}, 0);
    chk("rst_full", board_full, 0);
    chk("rst_win", {win_black, win_white}, 0);
    @(negedge clk); rst = 1'b1;

    for (int k = 0; k < vt.size(); k++) begin
      if (k == 5) begin
        drive(0, 0, 0, 0, 0, 0);
        row_sel = 4'd7; #1;
        chk("row7_black", row_black, 15'h0080);
        chk("row7_white", row_white, 0);
        chk("last_after3", {last_i, last_j, last_color}, {4'd5, 4'd5, 1'b0});
        win_req = 1; win_i = 4'd5; win_j = 4'd5;
        tick();
        chk("win55_valid", win_valid, 1);
        chk("win55_black", win_black, {9'h010, 9'h054, 9'h010, 9'h010});
        chk("win55_white", win_white, 0);
        win_req = 0;
        tick();
        chk("win_valid_pulse", win_valid, 0);
        chk("win_hold", win_black, {9'h010, 9'h054, 9'h010, 9'h010});
        win_req = 1; win_i = 4'd0; win_j = 4'd0;
        tick();
        chk("win00_black", win_black, {9'h000, 9'h080, 9'h000, 9'h000});
        win_req = 0;
      end
      drive(vt[k].clr, vt[k].undo, vt[k].place, vt[k].i, vt[k].j, vt[k].col);
      tick();
      chk($sformatf("v%0d_place_ack", k), place_ack, vt[k].ack);
      chk($sformatf("v%0d_place_err", k), place_err, vt[k].err);
      chk($sformatf("v%0d_undo_ack", k), undo_ack, vt[k].uack);
      chk($sformatf("v%0d_undo_err", k), undo_err, vt[k].uerr);
      chk($sformatf("v%0d_count", k), move_count, vt[k].cnt);
      chk($sformatf("v%0d_last_valid", k), last_valid, vt[k].cnt != 0);
      if (k == 8) begin
        for (int r = 0; r < 16; r++) begin
          row_sel = IW'(r); #1;
          chk($sformatf("empty_row%0d", r), {row_black, row_white}, 0);
        end
        chk("empty_last", {last_i, last_j, last_color}, 0);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("last_final", {last_i, last_j, last_color}, {4'd14, 4'd14, 1'b1});

    // Random phase against the model
    drive(1, 0, 0, 0, 0, 0);
    tick();
    m_apply(1, 0, 0, 0, 0, 0, ea, ee, eua, eue);
    exp_wb = {9'h000, 9'h080, 9'h000, 9'h000};
    exp_ww = '0;
    for (int n = 0; n < 400; n++) begin
      bit c, u, p, col, wr;
      int i, j, rs, wi, wj;
      c = ($urandom_range(0, 79) == 0);
      u = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 9) < 7);
      col = 1'($urandom);
      i = $urandom_range(0, 15); j = $urandom_range(0, 15);
      rs = $urandom_range(0, 15);
      wr = ($urandom_range(0, 2) == 0);
      wi = $urandom_range(0, 15); wj = $urandom_range(0, 15);
      drive(c, u, p, i, j, col);
      row_sel = IW'(rs); win_req = wr; win_i = IW'(wi); win_j = IW'(wj);
      if (wr) begin exp_wb = m_win(0, wi, wj); exp_ww = m_win(1, wi, wj); end
      m_apply(c, u, p, i, j, col, ea, ee, eua, eue);
      tick();
      chk("r_place_ack", place_ack, ea);
      chk("r_place_err", place_err, ee);
      chk("r_undo_ack", undo_ack, eua);
      chk("r_undo_err", undo_err, eue);
      chk("r_count", move_count, hq.size());
      chk("r_last_valid", last_valid, hq.size() > 0);
      if (hq.size() > 0) chk("r_last", {last_i, last_j, last_color}, {IW'(hq[$].i), IW'(hq[$].j), hq[$].c});
      else chk("r_last0", {last_i, last_j, last_color}, 0);
      chk("r_full", board_full, hq.size() == HD);
      for (int q = 0; q < BS; q++) begin
        er_b[q] = (rs < BS) ? mb[rs][q] : 1'b0;
        er_w[q] = (rs < BS) ? mw[rs][q] : 1'b0;
      end
      chk("r_row_black", row_black, er_b);
      chk("r_row_white", row_white, er_w);
      chk("r_win_valid", win_valid, wr);
      chk("r_win_black", win_black, exp_wb);
      chk("r_win_white", win_white, exp_ww);
    end
    drive(0, 0, 0, 0, 0, 0); win_req = 0;

    // Small board with four-entry history
    begin
      int seq_i [5] = '{0, 1, 2, 3, 4};
      for (int n = 0; n < 5; n++) begin
        place_req2 = 1; place_i2 = IW2'(seq_i[n]); place_j2 = IW2'(seq_i[n]); place_color2 = n[0];
        tick();
        chk($sformatf("s_ack%0d", n), place_ack2, n < 4);
        chk($sformatf("s_err%0d", n), place_err2, n == 4);
        chk($sformatf("s_full%0d", n), board_full2, n >= 3);
      end
      place_req2 = 0; undo_req2 = 1;
      tick();
      undo_req2 = 0;
      chk("s_undo_ack", undo_ack2, 1);
      chk("s_full_after_undo", board_full2, 0);
      chk("s_count_after_undo", move_count2, 3);
    end

    // Asynchronous reset in mid-cycle
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 1, 0); tick();
    chk("pre_rst_ack", place_ack, 1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_count", move_count, 0);
    chk("async_rst_ack", place_ack, 0);
    chk("async_rst_last", last_valid, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b1;
    tick();
    chk("post_rst_count", move_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
